// File: rtl/gpu_pkg.sv
// Shared GPU definitions.
// Purpose: instruction width, the field offsets of the packed 82-bit GPU
//          instruction, and the packed instruction typedef.
// Ports:   none (package).
package gpu_pkg;

  localparam int INST_W = 82;

  // Field offsets (LSB position of each field).
  localparam int INST_TYPE_LSB   = 0;
  localparam int VERTICE_NUM_LSB = 1;
  localparam int COORDS_LSB      = 2;   // 2..49
  localparam int LAYER_LSB       = 50;
  localparam int FILL_LSB        = 51;
  localparam int COLOR_LSB       = 52;  // 52..75
  localparam int TEXTURE_LSB     = 76;  // 76..77
  localparam int ALPHA_LSB       = 78;  // 78..81

  // Declared MSB-first so each member lands on the offsets above.
  typedef struct packed {
    logic [3:0]  alpha;
    logic [1:0]  texture;
    logic [23:0] color;
    logic        fill;
    logic        layer;
    logic [47:0] coords;
    logic        vertice_num;
    logic        inst_type;
  } inst_t;

endpackage

// File: rtl/inst_fifo_if.sv
// Host/decoder/control-facing bus of the instruction FIFO.
// Purpose: groups the push side (wenable, write_data), the pop side
//          (renable) and the status/head outputs.
// Modports: master = host + control unit (drives wenable/write_data/renable),
//           slave  = inst_fifo.
//
// Handshake: a push is accepted on a rising edge where wenable=1 and either
// full=0 or renable=1; otherwise it is dropped and overflow sets. A pop is
// accepted on a rising edge where renable=1 and empty=0; fifo_data holds the
// popped entry during that cycle. A pop on empty sets underflow and changes
// nothing else.
interface inst_fifo_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 82
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             wenable;
  logic [WIDTH-1:0] write_data;
  logic             renable;
  logic [WIDTH-1:0] fifo_data;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wenable, write_data, renable,
    input  fifo_data, empty, full, almost_full, count, overflow, underflow
  );

  modport slave (
    input  wenable, write_data, renable,
    output fifo_data, empty, full, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/inst_fifo_ram.sv
// Instruction FIFO storage.
// Purpose: DEPTH x WIDTH register file, one synchronous write port and one
//          combinational read port. The array has no reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module inst_fifo_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 82,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fifo.sv
// Instruction buffer in front of the instruction decoder.
// Purpose: first-word-fall-through FIFO of packed GPU instructions with a
//          separately held occupancy count and sticky overrun/underrun flags.
// Ports: clk, n_rst (async active-low), clear (sync flush),
//        bus (inst_fifo_if.slave): wenable, write_data, renable, fifo_data,
//        empty, full, almost_full, count, overflow, underflow.
// DEPTH must be a power of two >= 2 and match the interface instance.
module inst_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = INST_W
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  inst_fifo_if.slave    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] rdata;

  // Occupancy flags come only from the count, never from pointer equality.
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // When full, a same-cycle pop frees the slot the push lands in.
  assign push = bus.wenable && (!full || bus.renable);
  assign pop  = bus.renable && !empty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear) begin
      wptr        <= '0;
      rptr        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (bus.wenable && full && !bus.renable) begin
        overflow_q <= 1'b1;
      end
      if (bus.renable && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // A push suppressed by clear must not touch storage either; keeps the
  // array write strictly tied to an accepted push.
  inst_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (push && !clear),
    .waddr (wptr),
    .wdata (bus.write_data),
    .raddr (rptr),
    .rdata (rdata)
  );

  // Idle head reads as zero so the decoder never sees stale fields.
  assign bus.fifo_data   = empty ? '0 : rdata;
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.almost_full = (count_q >= CNT_W'(DEPTH - 1));
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_inst_fifo.sv
// Testbench for inst_fifo: directed scenarios plus randomized traffic,
// checked against a queue-based reference model.
module tb_inst_fifo;

  localparam int DEPTH = 8;
  localparam int W     = 82;

  logic clk;
  logic n_rst;
  logic clear;

  inst_fifo_if #(.DEPTH(DEPTH), .WIDTH(W)) bus ();

  inst_fifo #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_ovf;
  logic         exp_udf;
  int           n_checks;
  int           n_fail;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int sz;
    logic [W-1:0] head;
    sz   = exp_q.size();
    head = (sz > 0) ? exp_q[0] : '0;
    check("count",       W'(bus.count),       W'(sz));
    check("empty",       W'(bus.empty),       W'(sz == 0));
    check("full",        W'(bus.full),        W'(sz == DEPTH));
    check("almost_full", W'(bus.almost_full), W'(sz >= DEPTH - 1));
    check("overflow",    W'(bus.overflow),    W'(exp_ovf));
    check("underflow",   W'(bus.underflow),   W'(exp_udf));
    check("fifo_data",   bus.fifo_data,       head);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; drives one clock cycle, updates the model at
  // the rising edge and checks at the next falling edge.
  task automatic cycle(input logic we, input logic [W-1:0] wd, input logic re, input logic clr);
    int sz;
    bus.wenable    = we;
    bus.write_data = wd;
    bus.renable    = re;
    clear          = clr;
    @(posedge clk);
    sz = exp_q.size();
    if (clr) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      if (re && sz > 0) void'(exp_q.pop_front());
      if (we && (sz < DEPTH || re)) exp_q.push_back(wd);
      if (we && sz == DEPTH && !re) exp_ovf = 1'b1;
      if (re && sz == 0) exp_udf = 1'b1;
    end
    @(negedge clk);
    bus.wenable = 1'b0;
    bus.renable = 1'b0;
    clear       = 1'b0;
    check_state();
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    n_rst    = 1'b0;
    clear    = 1'b0;
    bus.wenable    = 1'b0;
    bus.renable    = 1'b0;
    bus.write_data = '0;

    // Reset state.
    #1;
    check_state();
    @(negedge clk);
    n_rst = 1'b1;

    // Push 1,2,3 then pop 3.
    for (int i = 1; i <= 3; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      check("inorder_head", bus.fifo_data, W'(i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    check("empty_after_3", W'(bus.empty), W'(1));

    // Fill to DEPTH, then overrun.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, W'(32'h100 + i), 1'b0, 1'b0);
    cycle(1'b1, W'(32'hDEAD), 1'b0, 1'b0);
    check("ovf_count", W'(bus.count), W'(DEPTH));
    check("ovf_flag",  W'(bus.overflow), W'(1));

    // Full: simultaneous push 0xAA and pop; 0xAA is the 8th subsequent pop.
    cycle(1'b1, W'(8'hAA), 1'b1, 1'b0);
    check("full_both_count", W'(bus.count), W'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("aa_eighth_pop", bus.fifo_data, W'(8'hAA));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end

    // Empty: simultaneous push 0x5 and pop.
    cycle(1'b1, W'(5), 1'b1, 1'b0);
    check("empty_both_head", bus.fifo_data, W'(5));
    check("empty_both_udf",  W'(bus.underflow), W'(1));

    // Clear, then reset asserted mid-transfer with 3 entries.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_word(), 1'b0, 1'b0);
    bus.wenable    = 1'b1;
    bus.write_data = rand_word();
    #2;
    n_rst = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    check_state();
    bus.wenable = 1'b0;
    @(negedge clk);
    check_state();
    n_rst = 1'b1;

    // Wrap-around: hold count at 3 with 20 push+pop cycles.
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_word(), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, rand_word(), 1'b1, 1'b0);

    // Clear with concurrent push.
    cycle(1'b1, W'(32'h77), 1'b0, 1'b1);
    check("clear_count", W'(bus.count), W'(0));
    check("clear_data",  bus.fifo_data, W'(0));

    // Randomized traffic with phase-varied bias to reach both extremes.
    for (int i = 0; i < 600; i++) begin
      int wp;
      int rp;
      wp = ((i / 50) % 2 == 0) ? 75 : 30;
      rp = ((i / 50) % 2 == 0) ? 30 : 75;
      cycle(($urandom_range(0, 99) < wp), rand_word(),
            ($urandom_range(0, 99) < rp), ($urandom_range(0, 99) < 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
